// File: rtl/efuse_pkg.sv
// rtl/efuse_pkg.sv - shared types, defaults and helpers for the eFuse controller
package efuse_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      SETUP,
      STROBE,
      HOLD,
      DONE
   } state_e;

   typedef enum logic {
      OP_RD,
      OP_PGM
   } op_e;

   localparam int DEF_EFUSE_BITS = 256;
   localparam int DEF_NR         = 64;
   localparam int DEF_DW         = 8;
   localparam int DEF_TRD_W      = 6;
   localparam int DEF_TPGM_W     = 10;
   localparam int DEF_TRD        = 0;
   localparam int DEF_TPGM       = 4;

   // Keeps derived vector widths legal when a ratio collapses to 1.
   function automatic int clog2_min1(input int value);
      int r;
      r = $clog2(value);
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/efuse_strobe_timer.sv
// rtl/efuse_strobe_timer.sv - loadable down-counter timing the macro strobes
//   clk, rst_n : clock and synchronous active-low reset
//   load       : load load_val into the counter (wins over en)
//   en         : count down by one while non-zero
//   load_val   : strobe width minus 1
//   zero       : counter is at zero (last strobe cycle when en is high)
module efuse_strobe_timer #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/efuse_ctrl.sv
// rtl/efuse_ctrl.sv - eFuse macro controller: word reads and bit-serial programming
//   clk, rst_n           : clock and synchronous active-low reset
//   rg_efuse_trd/tpgm    : read / program strobe width minus 1 (captured at accept)
//   read_start/read_sel  : read request and word index
//   pgm_start/pgm_sel    : program request and word index
//   pgm_data             : bits to blow (1 = blow); pgm_lock rejects programming
//   efuse_rdata          : macro read data byte
//   read_done/read_data  : read completion pulse and last completed word
//   pgm_done, cmd_err    : program completion pulse, rejected-command pulse
//   busy                 : operation in progress
//   efuse_aen_o/rden_o/pgmen_o/addr_o : macro address enable, strobes, bit address
module efuse_ctrl
   import efuse_pkg::*;
#(
   parameter  int EFUSE_BITS = DEF_EFUSE_BITS,
   parameter  int NR         = DEF_NR,
   parameter  int DW         = DEF_DW,
   parameter  int TRD_W      = DEF_TRD_W,
   parameter  int TPGM_W     = DEF_TPGM_W,
   localparam int RSEL       = EFUSE_BITS / NR,
   localparam int BYTE_NUM   = NR / DW,
   localparam int SW         = clog2_min1(RSEL),
   localparam int AW         = clog2_min1(EFUSE_BITS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [TRD_W-1:0]  rg_efuse_trd,
   input  logic [TPGM_W-1:0] rg_efuse_tpgm,
   input  logic              read_start,
   input  logic [SW-1:0]     read_sel,
   input  logic              pgm_start,
   input  logic [SW-1:0]     pgm_sel,
   input  logic [NR-1:0]     pgm_data,
   input  logic              pgm_lock,
   input  logic [DW-1:0]     efuse_rdata,
   output logic              read_done,
   output logic [NR-1:0]     read_data,
   output logic              pgm_done,
   output logic              cmd_err,
   output logic              busy,
   output logic              efuse_aen_o,
   output logic              efuse_rden_o,
   output logic              efuse_pgmen_o,
   output logic [AW-1:0]     efuse_addr_o
);

   localparam int TW    = max_int(TRD_W, TPGM_W);
   localparam int IW    = clog2_min1(NR);
   localparam int BW    = clog2_min1(BYTE_NUM);
   localparam int NR_SH = $clog2(NR);
   localparam int DW_SH = $clog2(DW);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [SW-1:0]     sel_q;
   logic [TRD_W-1:0]  trd_q;
   logic [TPGM_W-1:0] tpgm_q;
   logic [NR-1:0]     data_q;
   logic [NR-1:0]     shadow_q;
   logic [NR-1:0]     read_data_q;
   logic              cmd_err_q, cmd_err_d;
   logic              capture;
   logic              shadow_we;
   logic              rd_load;
   logic              last_idx;
   logic              tmr_load, tmr_en, tmr_zero;
   logic [TW-1:0]     tmr_val;
   logic [BW-1:0]     byte_idx;
   logic [AW-1:0]     addr_base, addr_off;

   // idx_q counts bytes during a read and fuse bits during programming.
   assign byte_idx = idx_q[BW-1:0];
   assign last_idx = (op_q == OP_RD) ? (idx_q == IW'(BYTE_NUM - 1))
                                     : (idx_q == IW'(NR - 1));

   // Captured timing is used so register writes mid-operation cannot stretch a strobe.
   assign tmr_load = (state_q == SETUP);
   assign tmr_en   = (state_q == STROBE);
   assign tmr_val  = (op_q == OP_RD) ? TW'(trd_q) : TW'(tpgm_q);

   efuse_strobe_timer #(
      .W (TW)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .en       (tmr_en),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      idx_d     = idx_q;
      capture   = 1'b0;
      cmd_err_d = 1'b0;
      shadow_we = 1'b0;
      rd_load   = 1'b0;
      case (state_q)
         IDLE: begin
            if (read_start) begin
               // Read wins; a simultaneous program request is dropped and flagged.
               state_d   = SETUP;
               op_d      = OP_RD;
               idx_d     = '0;
               capture   = 1'b1;
               cmd_err_d = pgm_start;
            end else if (pgm_start) begin
               if (pgm_lock) begin
                  cmd_err_d = 1'b1;
               end else begin
                  state_d = SCAN;
                  op_d    = OP_PGM;
                  idx_d   = '0;
                  capture = 1'b1;
               end
            end
         end
         SCAN: begin
            if (data_q[idx_q]) begin
               state_d = SETUP;
            end else if (last_idx) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         SETUP: begin
            state_d = STROBE;
         end
         STROBE: begin
            if (tmr_zero) begin
               state_d   = HOLD;
               shadow_we = (op_q == OP_RD);
            end
         end
         HOLD: begin
            if (last_idx) begin
               state_d = DONE;
               rd_load = (op_q == OP_RD);
            end else begin
               idx_d   = idx_q + IW'(1);
               state_d = (op_q == OP_RD) ? SETUP : SCAN;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= OP_RD;
         idx_q       <= '0;
         sel_q       <= '0;
         trd_q       <= '0;
         tpgm_q      <= '0;
         data_q      <= '0;
         shadow_q    <= '0;
         read_data_q <= '0;
         cmd_err_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         idx_q     <= idx_d;
         cmd_err_q <= cmd_err_d;
         if (capture) begin
            trd_q  <= rg_efuse_trd;
            tpgm_q <= rg_efuse_tpgm;
            sel_q  <= read_start ? read_sel : pgm_sel;
            data_q <= pgm_data;
         end
         if (shadow_we) begin
            shadow_q[DW*byte_idx +: DW] <= efuse_rdata;
         end
         if (rd_load) begin
            read_data_q <= shadow_q;
         end
      end
   end

   // Word base is sel*NR; read offsets step a whole data-port byte, program offsets one bit.
   assign addr_base = AW'(sel_q) << NR_SH;
   assign addr_off  = (op_q == OP_RD) ? (AW'(idx_q) << DW_SH) : AW'(idx_q);

   assign busy          = (state_q == SCAN) || (state_q == SETUP) ||
                          (state_q == STROBE) || (state_q == HOLD);
   assign efuse_aen_o   = (state_q == SETUP) || (state_q == STROBE);
   assign efuse_rden_o  = (state_q == STROBE) && (op_q == OP_RD);
   assign efuse_pgmen_o = (state_q == STROBE) && (op_q == OP_PGM);
   assign efuse_addr_o  = ((state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD))
                          ? (addr_base + addr_off) : '0;
   assign read_done     = (state_q == DONE) && (op_q == OP_RD);
   assign pgm_done      = (state_q == DONE) && (op_q == OP_PGM);
   assign read_data     = read_data_q;
   assign cmd_err       = cmd_err_q;

endmodule
